// File: rtl/sp_traceback_ctrl.sv
// Job sequencer for the grid shortest-path engine: kicks the engine, waits for it,
// then walks the direction memory P from the last cell back to the origin.
module sp_traceback_ctrl #(
  parameter int                  ROWS       = 4,
  parameter int                  COLS       = 4,
  parameter int                  A_WIDTH    = 16,
  parameter int                  D_WIDTH    = 8,
  parameter logic [D_WIDTH-1:0]  CODE_START = 8'h08,
  parameter logic [D_WIDTH-1:0]  CODE_RIGHT = 8'h09,
  parameter logic [D_WIDTH-1:0]  CODE_DOWN  = 8'h0A
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  output logic               Busy,
  output logic               Sp_Go,
  input  logic               Sp_Done,
  output logic               P_En,
  output logic               P_Rw,
  output logic [A_WIDTH-1:0] P_Addr,
  input  logic [D_WIDTH-1:0] P_In,
  output logic               Path_Valid,
  input  logic               Path_Ready,
  output logic [A_WIDTH-1:0] Path_Addr,
  output logic [D_WIDTH-1:0] Path_Dir,
  output logic               Path_Last,
  output logic               Done,
  output logic               Err
);

  typedef enum logic [3:0] {
    S_IDLE, S_GO, S_WAIT, S_RD, S_RW1, S_RW2, S_EVAL, S_EMIT, S_FIN, S_FAIL
  } state_t;

  localparam int                 SW        = $clog2(ROWS + COLS) + 1;
  localparam logic [A_WIDTH-1:0] LAST_CELL = A_WIDTH'(ROWS * COLS - 1);
  localparam logic [A_WIDTH-1:0] COLS_A    = A_WIDTH'(COLS);
  localparam logic [SW-1:0]      MAX_STEPS = SW'(ROWS + COLS - 1);

  state_t             state_reg, state_next;
  logic [A_WIDTH-1:0] cur_reg, cur_next;
  logic [SW-1:0]      steps_reg, steps_next;
  logic [D_WIDTH-1:0] dir_reg;

  logic               busy_reg, busy_next;
  logic               sp_go_reg, sp_go_next;
  logic               p_en_reg, p_en_next;
  logic [A_WIDTH-1:0] p_addr_reg, p_addr_next;
  logic               path_valid_reg, path_valid_next;
  logic [A_WIDTH-1:0] path_addr_reg, path_addr_next;
  logic [D_WIDTH-1:0] path_dir_reg, path_dir_next;
  logic               path_last_reg, path_last_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  logic dir_known, col_zero, row_zero, eval_err;

  // A step count reaching ROWS+COLS-1 means the walk is looping or malformed.
  always_comb begin
    dir_known = (dir_reg == CODE_START) || (dir_reg == CODE_RIGHT) || (dir_reg == CODE_DOWN);
    col_zero  = (cur_reg % COLS_A) == '0;
    row_zero  = cur_reg < COLS_A;
    eval_err  = !dir_known
             || ((dir_reg == CODE_RIGHT) && col_zero)
             || ((dir_reg == CODE_DOWN)  && row_zero)
             || ((dir_reg == CODE_START) && (cur_reg != '0))
             || (steps_reg == MAX_STEPS);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg      <= S_IDLE;
      cur_reg        <= '0;
      steps_reg      <= '0;
      dir_reg        <= '0;
      busy_reg       <= 1'b0;
      sp_go_reg      <= 1'b0;
      p_en_reg       <= 1'b0;
      p_addr_reg     <= '0;
      path_valid_reg <= 1'b0;
      path_addr_reg  <= '0;
      path_dir_reg   <= '0;
      path_last_reg  <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      steps_reg      <= steps_next;
      if (state_reg == S_RW2) dir_reg <= P_In;
      busy_reg       <= busy_next;
      sp_go_reg      <= sp_go_next;
      p_en_reg       <= p_en_next;
      p_addr_reg     <= p_addr_next;
      path_valid_reg <= path_valid_next;
      path_addr_reg  <= path_addr_next;
      path_dir_reg   <= path_dir_next;
      path_last_reg  <= path_last_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    steps_next = steps_reg;
    case (state_reg)
      S_IDLE: if (Start) state_next = S_GO;
      S_GO:   state_next = S_WAIT;
      S_WAIT: if (Sp_Done) begin
        state_next = S_RD;
        cur_next   = LAST_CELL;
        steps_next = '0;
      end
      S_RD:   state_next = S_RW1;
      S_RW1:  state_next = S_RW2;
      S_RW2:  state_next = S_EVAL;
      S_EVAL: state_next = eval_err ? S_FAIL : S_EMIT;
      S_EMIT: if (Path_Ready) begin
        if (path_last_reg) begin
          state_next = S_FIN;
        end else begin
          state_next = S_RD;
          cur_next   = cur_reg - ((path_dir_reg == CODE_RIGHT) ? A_WIDTH'(1) : COLS_A);
          steps_next = steps_reg + SW'(1);
        end
      end
      S_FIN:  state_next = S_IDLE;
      S_FAIL: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    busy_next       = state_next != S_IDLE;
    sp_go_next      = state_next == S_GO;
    p_en_next       = state_next == S_RD;
    p_addr_next     = (state_next == S_RD) ? cur_next : p_addr_reg;
    path_valid_next = state_next == S_EMIT;
    done_next       = state_next == S_FIN;
    err_next        = state_next == S_FAIL;
    path_addr_next  = path_addr_reg;
    path_dir_next   = path_dir_reg;
    path_last_next  = path_last_reg;
    if ((state_reg == S_EVAL) && (state_next == S_EMIT)) begin
      path_addr_next = cur_reg;
      path_dir_next  = dir_reg;
      path_last_next = dir_reg == CODE_START;
    end
  end

  assign Busy       = busy_reg;
  assign Sp_Go      = sp_go_reg;
  assign P_En       = p_en_reg;
  assign P_Rw       = 1'b0;
  assign P_Addr     = p_addr_reg;
  assign Path_Valid = path_valid_reg;
  assign Path_Addr  = path_addr_reg;
  assign Path_Dir   = path_dir_reg;
  assign Path_Last  = path_last_reg;
  assign Done       = done_reg;
  assign Err        = err_reg;

endmodule

// File: tb/tb_sp_traceback_ctrl.sv
// Scoreboard bench for sp_traceback_ctrl: a reference walk of the P grid queues the
// expected beats, and a monitor pops and compares them on every accepted handshake.
module tb_sp_traceback_ctrl;

  logic        Clk, Rst, Start, Sp_Done, Path_Ready;
  logic        Busy, Sp_Go, P_En, P_Rw, Path_Valid, Path_Last, Done, Err;
  logic [15:0] P_Addr, Path_Addr;
  logic [7:0]  P_In, Path_Dir;

  sp_traceback_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Busy(Busy), .Sp_Go(Sp_Go), .Sp_Done(Sp_Done),
    .P_En(P_En), .P_Rw(P_Rw), .P_Addr(P_Addr), .P_In(P_In),
    .Path_Valid(Path_Valid), .Path_Ready(Path_Ready), .Path_Addr(Path_Addr),
    .Path_Dir(Path_Dir), .Path_Last(Path_Last), .Done(Done), .Err(Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dir;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pmem [16];
  int n_checks = 0, n_pass = 0;
  int go_cnt = 0, done_cnt = 0, err_cnt = 0, beat_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // P memory: address captured on the first edge, data presented on the second.
  logic [15:0] rd_addr_q;
  logic        rd_pend;
  initial begin
    P_In = '0; rd_pend = 1'b0; rd_addr_q = '0;
  end
  always @(posedge Clk) begin
    rd_pend <= P_En;
    if (P_En) rd_addr_q <= P_Addr;
    if (rd_pend) P_In <= pmem[rd_addr_q[3:0]];
  end

  logic        stall_prev = 1'b0, last_acc = 1'b0;
  logic [15:0] stall_addr;
  logic [7:0]  stall_dir;
  always @(negedge Clk) begin
    if (Sp_Go) go_cnt++;
    if (Done)  done_cnt++;
    if (Err)   err_cnt++;
    if (last_acc) check("done_after_last", Done, 1);
    last_acc = 1'b0;
    if (stall_prev) begin
      check("stall_valid", Path_Valid, 1);
      check("stall_addr", Path_Addr, stall_addr);
      check("stall_dir", Path_Dir, stall_dir);
    end
    stall_prev = 1'b0;
    if (Path_Valid && !Path_Ready) begin
      check("stall_pen", P_En, 0);
      stall_prev = 1'b1;
      stall_addr = Path_Addr;
      stall_dir  = Path_Dir;
    end
    if (Path_Valid && Path_Ready) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        check("beat_extra", 1, 0);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_addr", Path_Addr, b.addr);
        check("beat_dir", Path_Dir, b.dir);
        check("beat_last", Path_Last, b.last);
        last_acc = Path_Last;
      end
    end
  end

  task automatic set_grid();
    for (int i = 0; i < 16; i++) pmem[i] = 8'h0A;
    pmem[0] = 8'h08; pmem[1] = 8'h09; pmem[2] = 8'h09; pmem[3] = 8'h09;
  endtask

  // Reference walk from the last cell toward the origin.
  task automatic build_expected(output bit ok, output int n);
    int cur = 15, steps = 0;
    logic [7:0] d;
    beat_t b;
    ok = 0; n = 0;
    forever begin
      d = pmem[cur];
      if (!(d == 8'h08 || d == 8'h09 || d == 8'h0A) || (d == 8'h09 && cur % 4 == 0) ||
          (d == 8'h0A && cur < 4) || (d == 8'h08 && cur != 0) || steps == 7) break;
      b.addr = 16'(cur); b.dir = d; b.last = (d == 8'h08);
      exp_q.push_back(b); n++;
      if (d == 8'h08) begin ok = 1; break; end
      cur = (d == 8'h09) ? cur - 1 : cur - 4;
      steps++;
    end
  endtask

  task automatic run_job(input string name, input bit hold_start, input int stall_beat,
                         input int stall_len, input bit stray);
    bit ok; int n_exp; int cyc = 0; int sd_timer = 0; int stall_left = stall_len; bit stray_sent = 0;
    exp_q.delete();
    build_expected(ok, n_exp);
    go_cnt = 0; done_cnt = 0; err_cnt = 0; beat_cnt = 0;
    @(posedge Clk); #1; Start = 1'b1;
    while (done_cnt == 0 && err_cnt == 0 && cyc < 400) begin
      @(posedge Clk); #1; cyc++;
      if (!hold_start || Done || Err) Start = 1'b0;
      Sp_Done = 1'b0;
      if (Sp_Go) sd_timer = 3;
      else if (sd_timer > 0) begin
        sd_timer--;
        if (sd_timer == 0) Sp_Done = 1'b1;
      end
      if (stray && P_En && !stray_sent) begin Sp_Done = 1'b1; stray_sent = 1; end
      Path_Ready = 1'b1;
      if (Path_Valid && beat_cnt == stall_beat && stall_left > 0) begin
        Path_Ready = 1'b0; stall_left--;
      end
    end
    if (cyc >= 400) check({name, "_timeout"}, 0, 1);
    Start = 1'b0; Sp_Done = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check({name, "_go_cnt"}, go_cnt, 1);
    check({name, "_done_cnt"}, done_cnt, ok ? 1 : 0);
    check({name, "_err_cnt"}, err_cnt, ok ? 0 : 1);
    check({name, "_beats"}, beat_cnt, n_exp);
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_busy_end"}, Busy, 0);
    $display("job %s: beats=%0d done=%0d err=%0d", name, beat_cnt, done_cnt, err_cnt);
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Sp_Done = 1'b0; Path_Ready = 1'b1;
    set_grid();
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outs", {Busy, Sp_Go, P_En, P_Rw, Path_Valid, Path_Last, Done, Err}, 0);
    check("reset_paddr", P_Addr, 0);
    check("reset_path_addr", Path_Addr, 0);
    Rst = 1'b0;

    // Asynchronous reset while the controller waits on the engine.
    @(posedge Clk); #1; Start = 1'b1;
    for (int i = 0; i < 20 && !Sp_Go; i++) begin
      @(posedge Clk); #1; Start = 1'b0;
    end
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #4; check("wait_busy_pre", Busy, 1);
    Rst = 1'b1;
    #1; check("midreset_outs", {Busy, Sp_Go, P_En, Path_Valid, Path_Last, Done, Err}, 0);
    @(posedge Clk); #1; Rst = 1'b0;
    repeat (4) @(posedge Clk);
    #1; check("after_reset_idle", {Busy, Done, Err}, 0);
    $display("job reset_in_wait: busy=%0d", Busy);

    run_job("basic", 0, -1, 0, 0);
    run_job("stall", 0, 1, 3, 0);
    pmem[15] = 8'h55;
    run_job("bad_code", 0, -1, 0, 0);
    set_grid();
    for (int i = 12; i < 16; i++) pmem[i] = 8'h09;
    run_job("col0_right", 0, -1, 0, 0);
    set_grid();
    run_job("held_start", 1, -1, 0, 1);
    check("p_rw_zero", P_Rw, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
